accel_avg_bcd: RTL and testbench

ACCEL_AVG_BCD -- requirements
Module: accel_avg_bcd

---
 rtl/accel_avg_bcd.sv | 120 ++++++++++++
 tb/tb_accel_avg_bcd.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/accel_avg_bcd.sv
// Block averager for 12-bit accelerometer samples with a sequential binary-to-BCD
// converter that formats the result for a seven-segment display word.
module accel_avg_bcd #(
  parameter int AVG_LOG2 = 3
) (
  input  logic        i_clk_100MHZ,
  input  logic        i_rst,
  input  logic [11:0] i_sample,
  input  logic        i_sample_valid,
  output logic [31:0] o_display_word,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int SUM_W = 12 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                   state, state_next;
  logic signed [SUM_W-1:0]  sum, sum_next;
  logic [CNT_W-1:0]         count;
  logic                     block_done;
  logic [11:0]              avg;
  logic [11:0]              avg_reg;
  logic [11:0]              mag;
  logic                     neg;
  logic [15:0]              bcd;
  logic [15:0]              bcd_adj;
  logic [15:0]              bcd_shifted;
  logic [3:0]               bit_cnt;

  // The average is taken from the sum including the completing sample.
  always_comb begin
    sum_next   = sum + {{AVG_LOG2{i_sample[11]}}, i_sample};
    avg        = 12'(sum_next >>> AVG_LOG2);
    block_done = i_sample_valid && (count == LAST_CNT);
  end

  always_ff @(posedge i_clk_100MHZ) begin
    if (i_rst) begin
      sum   <= '0;
      count <= '0;
    end else if (i_sample_valid) begin
      if (block_done) begin
        sum   <= '0;
        count <= '0;
      end else begin
        sum   <= sum_next;
        count <= count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk_100MHZ) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (block_done) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (bit_cnt == 4'd11) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction: nibbles of 5 or more get +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_shifted = {bcd_adj[14:0], mag[11]};
  end

  always_ff @(posedge i_clk_100MHZ) begin
    if (i_rst) begin
      avg_reg        <= '0;
      mag            <= '0;
      neg            <= 1'b0;
      bcd            <= '0;
      bit_cnt        <= '0;
      o_display_word <= '0;
      o_done         <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_overrun <= block_done && (state != IDLE);
      case (state)
        IDLE: begin
          if (block_done) avg_reg <= avg;
        end
        LOAD: begin
          neg     <= avg_reg[11];
          mag     <= avg_reg[11] ? (~avg_reg + 12'd1) : avg_reg;
          bcd     <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          bcd     <= bcd_shifted;
          mag     <= {mag[10:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd11) begin
            o_display_word <= {(neg ? 4'hF : 4'h0), avg_reg, bcd_shifted};
            o_done         <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_accel_avg_bcd.sv
// Directed bench for accel_avg_bcd: averaging, BCD formatting, latency, overrun
// and reset behaviour against hand-computed display words.
module tb_accel_avg_bcd;

  logic        clk;
  logic        i_rst;
  logic [11:0] i_sample;
  logic        i_sample_valid;
  logic [31:0] o_display_word;
  logic        o_done;
  logic        o_busy;
  logic        o_overrun;

  int compare_count = 0;
  int fail_count    = 0;

  accel_avg_bcd #(.AVG_LOG2(3)) dut (
    .i_clk_100MHZ  (clk),
    .i_rst         (i_rst),
    .i_sample      (i_sample),
    .i_sample_valid(i_sample_valid),
    .o_display_word(o_display_word),
    .o_done        (o_done),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [11:0] sample, input logic valid);
    i_sample       = sample;
    i_sample_valid = valid;
    tick();
  endtask

  // Sends eight samples (s[0] first); returns in the cycle after the completing sample.
  task automatic send_block(input string tag, input logic [7:0][11:0] s, input int gap);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(s[i], 1'b1);
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          apply_stimulus(12'h000, 1'b0);
          check_output({tag, " busy_gap"}, 32'(o_busy), 32'd0);
        end
      end
    end
    i_sample_valid = 1'b0;
  endtask

  // Entered in cycle N+1; walks to N+15 checking busy, done latency and word.
  task automatic wait_conversion(input string tag, input logic [31:0] exp_word);
    i_sample_valid = 1'b0;
    check_output({tag, " busy_load"}, 32'(o_busy), 32'd1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_output({tag, " done_early"}, 32'(o_done), 32'd0);
    end
    check_output({tag, " busy_last"}, 32'(o_busy), 32'd1);
    tick();
    check_output({tag, " done"}, 32'(o_done), 32'd1);
    check_output({tag, " word"}, o_display_word, exp_word);
    check_output({tag, " busy_idle"}, 32'(o_busy), 32'd0);
    check_output({tag, " overrun"}, 32'(o_overrun), 32'd0);
    tick();
    check_output({tag, " done_pulse"}, 32'(o_done), 32'd0);
    check_output({tag, " word_hold"}, o_display_word, exp_word);
  endtask

  initial begin
    i_rst          = 1'b1;
    i_sample       = 12'h7FF;
    i_sample_valid = 1'b1;
    tick();
    tick();
    check_output("rst word", o_display_word, 32'h0000_0000);
    check_output("rst done", 32'(o_done), 32'd0);
    check_output("rst busy", 32'(o_busy), 32'd0);
    check_output("rst overrun", 32'(o_overrun), 32'd0);
    i_rst          = 1'b0;
    i_sample_valid = 1'b0;
    tick();

    $display("[TB] basic blocks");
    send_block("p100", {8{12'h064}}, 0);
    wait_conversion("p100", 32'h0064_0100);
    send_block("m5", {8{12'hFFB}}, 0);
    wait_conversion("m5", 32'hFFFB_0005);
    send_block("m2048", {8{12'h800}}, 0);
    wait_conversion("m2048", 32'hF800_2048);
    send_block("p2047", {8{12'h7FF}}, 0);
    wait_conversion("p2047", 32'h07FF_2047);
    send_block("trunc", {12'hFFE, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h001}, 0);
    wait_conversion("trunc", 32'hFFFF_0001);

    $display("[TB] mixed and gapped");
    send_block("mix", {12'd80, 12'd70, 12'd60, 12'd50, 12'd40, 12'd30, 12'd20, 12'd10}, 0);
    wait_conversion("mix", 32'h002D_0045);
    send_block("gap", {12'd80, 12'd70, 12'd60, 12'd50, 12'd40, 12'd30, 12'd20, 12'd10}, 3);
    wait_conversion("gap", 32'h002D_0045);

    $display("[TB] overrun");
    send_block("ovr1", {8{12'h064}}, 0);
    for (int i = 0; i < 7; i++) apply_stimulus(12'h12C, 1'b1);
    check_output("ovr pre", 32'(o_overrun), 32'd0);
    apply_stimulus(12'h12C, 1'b1);
    i_sample_valid = 1'b0;
    check_output("ovr pulse", 32'(o_overrun), 32'd1);
    check_output("ovr busy", 32'(o_busy), 32'd1);
    tick();
    check_output("ovr pulse_end", 32'(o_overrun), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check_output("ovr done_early", 32'(o_done), 32'd0);
    tick();
    check_output("ovr done", 32'(o_done), 32'd1);
    check_output("ovr word", o_display_word, 32'h0064_0100);
    for (int i = 0; i < 15; i++) begin
      tick();
      check_output("ovr no_second_done", 32'(o_done), 32'd0);
    end
    send_block("post_ovr", {8{12'hFFB}}, 0);
    wait_conversion("post_ovr", 32'hFFFB_0005);

    $display("[TB] completion in done cycle");
    send_block("edgeA", {8{12'h064}}, 0);
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 7; i++) apply_stimulus(12'hFFB, 1'b1);
    check_output("edgeA done", 32'(o_done), 32'd1);
    check_output("edgeA word", o_display_word, 32'h0064_0100);
    apply_stimulus(12'hFFB, 1'b1);
    wait_conversion("edgeB", 32'hFFFB_0005);

    $display("[TB] reset during shift");
    send_block("rstA", {8{12'h7FF}}, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(12'h7FF, 1'b1);
    check_output("rstA busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    tick();
    check_output("rstA word", o_display_word, 32'h0000_0000);
    check_output("rstA done", 32'(o_done), 32'd0);
    check_output("rstA busy0", 32'(o_busy), 32'd0);
    check_output("rstA overrun", 32'(o_overrun), 32'd0);
    i_rst          = 1'b0;
    i_sample_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check_output("rstA no_done", 32'(o_done), 32'd0);
    end
    send_block("rstB", {8{12'h7FF}}, 0);
    wait_conversion("rstB", 32'h07FF_2047);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
